// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and baud helper for the UART transmitter
package uart_pkg;

  localparam int FRAME_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Rounded to the nearest clock so the bit period error stays below half a cycle.
  function automatic int calc_bit_cycles(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - byte write handshake between register logic and the transmitter
interface uart_tx_serializer_if;
  import uart_pkg::*;

  logic                       wr_valid;
  logic [FRAME_DATA_BITS-1:0] wr_data;
  logic                       wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - power-of-two depth byte FIFO with full/empty and occupancy count
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [FRAME_DATA_BITS-1:0] push_data,
  input  logic                       pop,
  output logic [FRAME_DATA_BITS-1:0] pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [AW:0]                count
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [FRAME_DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]              wr_ptr;
  logic [AW-1:0]              rd_ptr;
  logic                       push_en;
  logic                       pop_en;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("uart_byte_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign push_en  = push && !full;
  assign pop_en   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap on their own; the separate count disambiguates full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - FIFO-buffered 8N1 UART transmitter; UART_TX_PARITY_EN adds an even parity bit
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  uart_tx_serializer_if.slave         wr,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int BIT_CYCLES = calc_bit_cycles(CLK_FREQ, BAUD);
  localparam int CW         = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [2:0]    LAST_DATA = 3'(FRAME_DATA_BITS - 1);

  generate
    if (BIT_CYCLES < 2) begin : g_baud_check
      $error("uart_tx_serializer: CLK_FREQ/BAUD gives fewer than 2 cycles per bit");
    end
  endgenerate

  tx_state_t                  state_q, state_d;
  logic [CW-1:0]              baud_cnt_q, baud_cnt_d;
  logic [2:0]                 bit_idx_q, bit_idx_d;
  logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
  logic                       txd_q, txd_d;
  logic                       bit_end;
  logic                       fifo_pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [FRAME_DATA_BITS-1:0] fifo_data;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr.wr_valid),
    .push_data (wr.wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign wr.wr_ready = !fifo_full;
  assign bit_end     = (baud_cnt_q == BIT_LAST);
  assign busy        = (state_q != IDLE) || (fifo_count != '0);
  assign txd         = txd_q;

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
    end
  end

  // txd_d follows the current state, so the line lags the FSM by exactly one flop stage.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    txd_d      = 1'b1;
    fifo_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          state_d  = START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_data;
`endif
        end
      end
      START: begin
        txd_d = 1'b0;
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        txd_d = shift_q[0];
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        txd_d = parity_q;
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        txd_d = 1'b1;
        if (bit_end) begin
          // A queued byte starts immediately so frames run back-to-back.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_data;
            state_d  = START;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_data;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - directed self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;

  localparam int BC = 434;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * BC;

  typedef struct {
    logic [7:0] data;
    logic       start;
    logic       par;
    logic       stop;
    int         fall;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       txd;
  logic       busy;
  logic [3:0] fifo_count;
  int         cyc = 0;
  int         total = 0;
  int         passed = 0;
  int         failed = 0;
  frame_t     rxq[$];

  uart_tx_serializer_if bus ();

  uart_tx_serializer #(
    .CLK_FREQ   (50_000_000),
    .BAUD       (115200),
    .FIFO_DEPTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr         (bus),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Line receiver: detects the start edge, samples mid-bit, drops frames cut by reset.
  initial begin : rx_monitor
    frame_t     f;
    logic [10:0] bits;
    logic       abort;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txd === 1'b0) begin
        f.fall = cyc;
        abort  = 1'b0;
        bits   = '0;
        for (int k = 0; k < NB && !abort; k++) begin
          for (int j = 0; j < ((k == 0) ? BC / 2 : BC) && !abort; j++) begin
            @(negedge clk);
            if (rst_n !== 1'b1) abort = 1'b1;
          end
          bits[k] = txd;
        end
        if (!abort) begin
          f.start = bits[0];
          f.data  = bits[8:1];
          f.par   = (NB == 11) ? bits[9] : 1'b0;
          f.stop  = bits[NB-1];
          rxq.push_back(f);
          $display("uart received 0x%02h, ASCII: %c", f.data, f.data);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t;
    t = 0;
    while (rxq.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
  endtask

  initial begin : stimulus
    int          bad;
    int          bfall;
    int          acc;
    int          c0;
    int          t;
    logic [10:0] pat;

    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(bus.wr_ready), 32'd1);
    check("rst_count", 32'(fifo_count), 32'd0);
    rst_n = 1'b1;

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || bus.wr_ready !== 1'b1 || fifo_count !== 4'd0) bad++;
    end
    check("idle_1000", 32'(bad), 32'd0);

    // Single byte 0x55: latency, exact bit widths, busy release.
    rxq.delete();
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h55;
    @(negedge clk);
    acc = cyc;
    bus.wr_valid = 1'b0;
    t = 0;
    while (txd !== 1'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("start_latency", 32'(cyc - acc), 32'd2);
    pat = 11'h7ff;
    pat[0] = 1'b0;
    pat[8:1] = 8'h55;
    if (NB == 11) pat[9] = 1'b0;
    bad = 0;
    bfall = -1;
    for (int i = 0; i < FRAME; i++) begin
      if (txd !== pat[i / BC]) bad++;
      if (bfall < 0 && busy === 1'b0) bfall = i;
      @(negedge clk);
    end
    check("x55_levels", 32'(bad), 32'd0);
    check("x55_busy_fall", 32'(bfall), 32'(FRAME - 1));
    check("x55_rx_count", 32'(rxq.size()), 32'd1);
    if (rxq.size() > 0) begin
      check("x55_rx_data", 32'(rxq[0].data), 32'h55);
      check("x55_rx_stop", 32'(rxq[0].stop), 32'd1);
    end

    // Nine bytes back-to-back into an 8-deep FIFO, tenth must stall.
    wait_idle("idle_before_burst", 1000);
    rxq.delete();
    bad = 0;
    for (int k = 0; k < 9; k++) begin
      if (bus.wr_ready !== 1'b1) bad++;
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'(8'h41 + k);
      @(negedge clk);
    end
    check("burst_ready", 32'(bad), 32'd0);
    bus.wr_data = 8'h4a;
    check("tenth_ready", 32'(bus.wr_ready), 32'd0);
    check("full_count", 32'(fifo_count), 32'd8);
    @(negedge clk);
    check("tenth_held", 32'(fifo_count), 32'd8);
    bus.wr_valid = 1'b0;
    wait_frames(9, 9 * FRAME + 1000);
    check("burst_rx_count", 32'(rxq.size()), 32'd9);
    bad = 0;
    for (int k = 0; k < rxq.size(); k++) begin
      if (rxq[k].data !== 8'(8'h41 + k) || rxq[k].stop !== 1'b1) bad++;
      if (k > 0 && rxq[k].fall - rxq[k-1].fall != FRAME) bad++;
    end
    check("burst_order_gap", 32'(bad), 32'd0);

    // Push on the exact stop-end pop edge with three bytes queued.
    wait_idle("idle_before_pushpop", 2 * FRAME);
    rxq.delete();
    c0 = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'(8'h60 + k);
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
    while (cyc < c0 + FRAME) @(negedge clk);
    check("pushpop_pre", 32'(fifo_count), 32'd3);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h64;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    check("pushpop_post", 32'(fifo_count), 32'd3);
    wait_frames(5, 5 * FRAME + 1000);
    check("pushpop_rx_count", 32'(rxq.size()), 32'd5);
    bad = 0;
    for (int k = 0; k < rxq.size(); k++) begin
      if (rxq[k].data !== 8'(8'h60 + k)) bad++;
    end
    check("pushpop_order", 32'(bad), 32'd0);

    // Asynchronous reset in the middle of data bit 2 of 0xA3.
    wait_idle("idle_before_reset", 2 * FRAME);
    rxq.delete();
    c0 = cyc + 1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'ha3;
    @(negedge clk);
    bus.wr_data  = 8'h11;
    @(negedge clk);
    bus.wr_data  = 8'h22;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    repeat (3 * BC + 200) @(negedge clk);
    check("pre_reset_txd", 32'(txd), 32'd0);
    check("pre_reset_count", 32'(fifo_count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_txd", 32'(txd), 32'd1);
    check("async_count", 32'(fifo_count), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rxq.delete();
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h0d;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    wait_frames(1, FRAME + 100);
    repeat (FRAME + 500) @(negedge clk);
    check("post_reset_rx_count", 32'(rxq.size()), 32'd1);
    if (rxq.size() > 0) begin
      check("post_reset_data", 32'(rxq[0].data), 32'h0d);
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of 0x07 is 1; the frame is eleven bit periods.
    wait_idle("idle_before_parity", 1000);
    rxq.delete();
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h07;
    @(negedge clk);
    acc = cyc;
    bus.wr_valid = 1'b0;
    t = 0;
    while (busy !== 1'b0 && t < FRAME + 100) begin
      @(negedge clk);
      t++;
    end
    check("parity_frame_len", 32'(cyc - acc), 32'd4775);
    check("parity_rx_count", 32'(rxq.size()), 32'd1);
    if (rxq.size() > 0) begin
      check("parity_data", 32'(rxq[0].data), 32'h07);
      check("parity_bit", 32'(rxq[0].par), 32'd1);
      check("parity_stop", 32'(rxq[0].stop), 32'd1);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
